// File: rtl/cache_fill_fsm.sv
// Cache line fill initiator: on a miss, issues eight word reads for the 16-byte block,
// steers each returned word into the data array and writes the tag with the last word.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic                  fsm_busy,
  output logic                  write_data_array,
  output logic [2:0]            cache_word_offset,
  output logic [15:0]           cache_data,
  output logic                  write_tag_array,
  output logic                  fill_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-5:0] base_q, base_d;
  logic [3:0]            issue_cnt_q, issue_cnt_d;
  logic [3:0]            recv_cnt_q, recv_cnt_d;
  logic                  accept;

  // The byte offset within the block is irrelevant: fills always start at word 0.
  logic [3:0]            unused_miss_offset;
  assign unused_miss_offset = miss_address[3:0];

  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    issue_cnt_d       = issue_cnt_q;
    recv_cnt_d        = recv_cnt_q;
    accept            = 1'b0;
    memory_address    = '0;
    mem_enable        = 1'b0;
    mem_wr            = 1'b0;
    fsm_busy          = 1'b0;
    write_data_array  = 1'b0;
    cache_word_offset = 3'd0;
    cache_data        = memory_data;
    write_tag_array   = 1'b0;
    fill_done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d      = miss_address[ADDR_WIDTH-1:4];
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 4'd0;
          state_d     = FILL;
        end
      end

      FILL: begin
        fsm_busy       = 1'b1;
        mem_enable     = (issue_cnt_q < 4'd8);
        memory_address = {base_q, issue_cnt_q[2:0], 1'b0};
        if (mem_enable) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end

        // Only words that answer an already-issued request are taken.
        accept = memory_data_valid && (recv_cnt_q < issue_cnt_q);
        if (accept) begin
          write_data_array  = 1'b1;
          cache_word_offset = recv_cnt_q[2:0];
          recv_cnt_d        = recv_cnt_q + 4'd1;
          if (recv_cnt_q == 4'd7) begin
            write_tag_array = 1'b1;
            state_d         = DONE;
          end
        end
      end

      DONE: begin
        fsm_busy  = 1'b1;
        fill_done = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: memory responses are driven cycle by cycle from
// hand-written valid masks, and every cycle's outputs are checked against fixed expectations.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = 16'h0;
  logic [15:0] memory_address;
  logic        mem_enable;
  logic        mem_wr;
  logic        fsm_busy;
  logic        write_data_array;
  logic [2:0]  cache_word_offset;
  logic [15:0] cache_data;
  logic        write_tag_array;
  logic        fill_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  cache_fill_fsm #(.ADDR_WIDTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .memory_address    (memory_address),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .cache_word_offset (cache_word_offset),
    .cache_data        (cache_data),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a new cycle, drives that cycle's inputs, and leaves time for outputs to settle.
  task automatic tick(input logic r, input logic m, input logic [15:0] ma,
                      input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst               = r;
    miss_detected     = m;
    miss_address      = ma;
    memory_data_valid = v;
    memory_data       = d;
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ctl"}, {26'd0, mem_enable, mem_wr, fsm_busy, write_data_array,
                        write_tag_array, fill_done}, 32'd0);
    chk({tag, " addr"}, {16'd0, memory_address}, 32'd0);
    chk({tag, " off"}, {29'd0, cache_word_offset}, 32'd0);
    chk({tag, " cdata"}, {16'd0, cache_data}, {16'd0, memory_data});
  endtask

  task automatic idle_cycles(input string tg, input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 16'h0, v, 16'h5A00 + 16'(i));
      chk_idle($sformatf("%s i%0d", tg, i));
    end
  endtask

  // One fill: cycle 0 raises the miss; bit c of vmask drives data_valid in cycle c and
  // bit c of wmask says whether a data-array write is expected in cycle c.
  task automatic fill(input string tg, input logic [15:0] maddr, input logic [15:0] base,
                      input logic [31:0] vmask, input logic [31:0] wmask,
                      input logic hold_miss, input logic [15:0] hold_addr);
    int          tag_cyc;
    int          cnt;
    int          k;
    logic [15:0] d;
    tag_cyc = 0;
    cnt     = 0;
    for (int i = 0; i < 32; i++) begin
      if (wmask[i]) begin
        cnt++;
        if (cnt == 8) tag_cyc = i;
      end
    end

    tick(1'b0, 1'b1, maddr, vmask[0], 16'hBEEF);
    chk_idle({tg, " c0"});

    k = 0;
    for (int c = 1; c <= tag_cyc + 1; c++) begin
      d = 16'hA000 + 16'(k);
      tick(1'b0, hold_miss, hold_addr, vmask[c], d);
      chk($sformatf("%s c%0d en", tg, c), {31'd0, mem_enable}, {31'd0, (c <= 8)});
      if (c <= 8)
        chk($sformatf("%s c%0d addr", tg, c), {16'd0, memory_address},
            {16'd0, base + 16'(2 * (c - 1))});
      chk($sformatf("%s c%0d wr", tg, c), {31'd0, write_data_array}, {31'd0, wmask[c]});
      if (wmask[c]) begin
        chk($sformatf("%s c%0d off", tg, c), {29'd0, cache_word_offset}, k);
        chk($sformatf("%s c%0d cdata", tg, c), {16'd0, cache_data}, {16'd0, d});
      end
      chk($sformatf("%s c%0d tag", tg, c), {31'd0, write_tag_array}, {31'd0, (c == tag_cyc)});
      chk($sformatf("%s c%0d done", tg, c), {31'd0, fill_done}, {31'd0, (c == tag_cyc + 1)});
      chk($sformatf("%s c%0d busy", tg, c), {31'd0, fsm_busy}, 32'd1);
      chk($sformatf("%s c%0d memwr", tg, c), {31'd0, mem_wr}, 32'd0);
      if (wmask[c]) k++;
    end
  endtask

  initial begin
    // Reset for two cycles, then idle with a few spurious valids.
    tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    idle_cycles("rst_idle", 10, 1'b0);
    idle_cycles("idle_vld", 10, 1'b1);

    // Basic fill, latency 4; a valid during DONE (cycle 13) must be ignored.
    fill("basic", 16'h1236, 16'h1230, 32'h0000_3FE0, 32'h0000_1FE0, 1'b0, 16'h0);
    idle_cycles("basic_after", 3, 1'b0);

    // Top-of-memory block, latency 1: no wrap past 0xFFFE.
    fill("top", 16'hFFFF, 16'hFFF0, 32'h0000_03FC, 32'h0000_03FC, 1'b0, 16'h0);
    idle_cycles("top_after", 3, 1'b0);

    // Bubbled responses, plus valids in IDLE (cycle 0) and with nothing outstanding (cycle 1).
    fill("gaps", 16'h0A5C, 16'h0A50, 32'h0000_5B6B, 32'h0000_5B68, 1'b0, 16'h0);
    idle_cycles("gaps_after", 3, 1'b0);

    // Reset in cycle 4 of a fill while memory keeps answering.
    tick(1'b0, 1'b1, 16'h1236, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b1, 16'hA000);
    chk("mrst c3 wr", {31'd0, write_data_array}, 32'd1);
    chk("mrst c3 busy", {31'd0, fsm_busy}, 32'd1);
    tick(1'b1, 1'b0, 16'h0, 1'b1, 16'hA001);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b1, 16'hA002 + 16'(i));
      chk_idle($sformatf("mrst i%0d", i));
    end

    // Back-to-back: miss held high with a new address through the first fill.
    fill("b2b1", 16'h2468, 16'h2460, 32'h0000_1FE0, 32'h0000_1FE0, 1'b1, 16'h4000);
    fill("b2b2", 16'h4000, 16'h4000, 32'h0000_1FE0, 32'h0000_1FE0, 1'b0, 16'h0);
    idle_cycles("b2b_after", 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
